// File: rtl/fifo2ddr_pack.sv
// Lane-packing FIFO: gathers RATIO narrow write lanes into one wide word
// (LSB-first) and stores committed words for registered single-cycle reads.
module fifo2ddr_pack #(
  parameter int DW_IN    = 64,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW_IN-1:0]           wr_data,
  input  logic                       flush,
  input  logic                       rd_en,
  output logic [DW_IN*RATIO-1:0]     rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(RATIO)-1:0]   lane_cnt,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW_OUT = DW_IN * RATIO;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int LW     = $clog2(RATIO);
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

  logic [DW_OUT-1:0] mem_r [DEPTH];
  logic [DW_OUT-1:0] pack_r;
  logic [DW_OUT-1:0] pack_next_s;
  logic [DW_OUT-1:0] commit_word_s;
  logic [DW_OUT-1:0] rd_data_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_next_s;
  logic [LW-1:0]     lane_cnt_r;
  logic              rd_valid_r;
  logic              empty_r;
  logic              full_r;
  logic              almost_full_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              flush_s;
  logic              commit_s;

  // Accept/commit decisions, all gated by the registered full/empty flags.
  always_comb begin
    wr_acc_s = wr_en & ~full_r;
    rd_acc_s = rd_en & ~empty_r;
    flush_s  = flush & ~full_r & ((lane_cnt_r != {LW{1'b0}}) | wr_en);
    commit_s = (wr_acc_s & (lane_cnt_r == LANE_LAST)) | flush_s;
    case ({commit_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Word assembly: held lanes below lane_cnt, the incoming lane at lane_cnt, zeros above.
  always_comb begin
    pack_next_s   = pack_r;
    commit_word_s = {DW_OUT{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if (LW'(k) < lane_cnt_r) begin
        commit_word_s[k*DW_IN +: DW_IN] = pack_r[k*DW_IN +: DW_IN];
      end else if ((LW'(k) == lane_cnt_r) && wr_acc_s) begin
        commit_word_s[k*DW_IN +: DW_IN] = wr_data;
        pack_next_s[k*DW_IN +: DW_IN]   = wr_data;
      end else begin
        commit_word_s[k*DW_IN +: DW_IN] = {DW_IN{1'b0}};
      end
    end
  end

  // Word storage; left uninitialised since reads only ever reach committed entries.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[wr_ptr_r] <= commit_word_s;
    end
  end

  // Pointers, occupancy, flags, sticky errors and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_r        <= {DW_OUT{1'b0}};
      rd_data_r     <= {DW_OUT{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      lane_cnt_r    <= {LW{1'b0}};
      rd_valid_r    <= 1'b0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
      underflow_r   <= 1'b0;
    end else begin
      pack_r <= pack_next_s;
      if (commit_s) begin
        lane_cnt_r <= {LW{1'b0}};
        wr_ptr_r   <= wr_ptr_r + AW'(1);
      end else if (wr_acc_s) begin
        lane_cnt_r <= lane_cnt_r + LW'(1);
      end
      if (rd_acc_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + AW'(1);
      end
      rd_valid_r    <= rd_acc_s;
      count_r       <= count_next_s;
      empty_r       <= (count_next_s == {CW{1'b0}});
      full_r        <= (count_next_s == CW'(DEPTH));
      almost_full_r <= (count_next_s >= CW'(AF_LEVEL));
      if (wr_en & full_r) begin
        overflow_r <= 1'b1;
      end
      if (rd_en & empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = almost_full_r;
  assign count       = count_r;
  assign lane_cnt    = lane_cnt_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_fifo2ddr_pack.sv
// Randomised scoreboard bench for fifo2ddr_pack against a queue-based model
// of committed words and pending lanes.
module tb_fifo2ddr_pack;
  localparam int DW_IN  = 64;
  localparam int RATIO  = 2;
  localparam int DEPTH  = 64;
  localparam int DW_OUT = DW_IN * RATIO;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DW_IN-1:0]  wr_data = '0;
  logic              flush = 1'b0;
  logic              rd_en = 1'b0;
  logic [DW_OUT-1:0] rd_data;
  logic              rd_valid, empty, full, almost_full, overflow, underflow;
  logic [6:0]        count;
  logic [0:0]        lane_cnt;

  fifo2ddr_pack #(.DW_IN(DW_IN), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .lane_cnt(lane_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW_OUT-1:0] pq[$];
  logic [DW_IN-1:0]  lanes[$];
  logic [DW_OUT-1:0] exp_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_rdv = 1'b0;
  int commits = 0;

  task automatic chk(input string name, input logic [DW_OUT-1:0] act, input logic [DW_OUT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented read word must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got word %0h expected no read", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic model(input bit we, input logic [DW_IN-1:0] wd, input bit fl, input bit re);
    bit m_full, m_empty;
    logic [DW_OUT-1:0] word;
    m_full  = (pq.size() == DEPTH);
    m_empty = (pq.size() == 0);
    m_rdv   = 1'b0;
    if (re) begin
      if (m_empty) m_unf = 1'b1;
      else begin
        exp_q.push_back(pq.pop_front());
        m_rdv = 1'b1;
      end
    end
    if (we) begin
      if (m_full) m_ovf = 1'b1;
      else lanes.push_back(wd);
    end
    if (lanes.size() == RATIO || (fl && !m_full && lanes.size() > 0)) begin
      word = '0;
      foreach (lanes[i]) word[i*DW_IN +: DW_IN] = lanes[i];
      pq.push_back(word);
      lanes.delete();
      commits++;
    end
  endtask

  task automatic check_state();
    chk("count", count, pq.size());
    chk("lane_cnt", lane_cnt, lanes.size());
    chk("empty", empty, pq.size() == 0);
    chk("full", full, pq.size() == DEPTH);
    chk("almost_full", almost_full, pq.size() >= DEPTH - 4);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("rd_valid", rd_valid, m_rdv);
  endtask

  // Called 1 time unit after a rising edge; drives one cycle and checks after the next edge.
  task automatic step(input bit we, input logic [DW_IN-1:0] wd, input bit fl, input bit re);
    wr_en = we; wr_data = wd; flush = fl; rd_en = re;
    model(we, wd, fl, re);
    @(posedge clk);
    #1;
    wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_almost_full", almost_full, 1'b0);
    chk("rst_count", count, '0);
    chk("rst_lane_cnt", lane_cnt, '0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    pq.delete(); lanes.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [DW_IN-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int guard;
    @(posedge clk);
    #1;
    do_reset();

    // Pack two lanes and read the word back.
    step(1'b1, 64'h1, 1'b0, 1'b0);
    step(1'b1, 64'h2, 1'b0, 1'b0);
    chk("pack_word_model", pq[0], {64'h2, 64'h1});
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    // Fill to full, then one extra lane.
    for (int i = 0; i < 2 * DEPTH + 1; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
    chk("fill_full", full, 1'b1);
    chk("fill_overflow", overflow, 1'b1);

    // Read plus write at full: write dropped, count falls to 63.
    step(1'b1, rnd64(), 1'b0, 1'b1);
    chk("conc_count", count, 7'd63);

    // Streaming with interleaved reads across pointer wrap.
    commits = 0;
    guard = 0;
    while (commits < 200 && guard < 4000) begin
      step($urandom_range(0, 99) < 70, rnd64(), 1'b0, $urandom_range(0, 99) < 35);
      guard++;
    end
    chk("stream_budget", guard < 4000, 1'b1);
    guard = 0;
    while (pq.size() > 0 && guard < 200) begin
      step(1'b0, 64'h0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    chk("underflow_set", underflow, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    // Flush of a single lane, then flush combined with the completing write.
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    chk("flushwr_count", count, 7'd1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    // Random mix including flushes.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, rnd64(), $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40);
    guard = 0;
    while (pq.size() > 0 && guard < 200) begin
      step(1'b0, 64'h0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    // Mid-operation reset with five words and one held lane.
    for (int i = 0; i < 11; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
    chk("pre_rst_count", count, 7'd5);
    chk("pre_rst_lane", lane_cnt, 1'b1);
    do_reset();
    step(1'b1, 64'h1234, 1'b0, 1'b0);
    step(1'b1, 64'h5678, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
